// File: rtl/led_mode_sched.sv
`default_nettype none
// ============================================================================
// led_mode_sched : key sync/debounce, pattern-select FSM and auto-play stepper
//                  driving the water lamp's active-low one-hot key input.
// Revision       : 1.0  initial release
// ============================================================================
module led_mode_sched #(
  parameter int unsigned DEB_MAX    = 1_000_000,
  parameter int unsigned PERIOD_MAX = 25_000_000,
  parameter int unsigned AUTO_STEPS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_i,
  input  logic       auto_en_i,
  output logic [3:0] sel_key_o,
  output logic [2:0] pattern_o,
  output logic       press_o,
  output logic       tick_o
);

  localparam int unsigned DEB_W  = $clog2(DEB_MAX + 1);
  localparam int unsigned PER_W  = $clog2(PERIOD_MAX + 1);
  localparam int unsigned STEP_W = $clog2(AUTO_STEPS + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_MAX - 1);
  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD_MAX - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(AUTO_STEPS - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MANUAL = 2'd1;
  localparam logic [1:0] S_AUTO   = 2'd2;

  localparam logic [2:0] PAT_DARK = 3'd4;

  function automatic logic [3:0] f_sel(input logic [2:0] pat);
    logic [3:0] sel;
    case (pat)
      3'd0:    sel = 4'b1110;
      3'd1:    sel = 4'b1101;
      3'd2:    sel = 4'b1011;
      3'd3:    sel = 4'b0111;
      default: sel = 4'b1111;
    endcase
    return sel;
  endfunction

  // Two-stage synchroniser; idles at "released" so reset never looks like a press.
  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 4'hF;
      sync_q <= 4'hF;
    end else begin
      meta_q <= key_i;
      sync_q <= meta_q;
    end
  end

  logic [3:0] fall_w;

  for (genvar k = 0; k < 4; k++) begin : g_deb
    logic [DEB_W-1:0] cnt_q;
    logic             stable_q;
    logic             settle_w;

    assign settle_w  = (sync_q[k] != stable_q) && (cnt_q == DEB_LAST);
    assign fall_w[k] = settle_w & ~sync_q[k];

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q    <= '0;
        stable_q <= 1'b1;
      end else if (sync_q[k] == stable_q) begin
        cnt_q    <= '0;
      end else if (cnt_q == DEB_LAST) begin
        cnt_q    <= '0;
        stable_q <= sync_q[k];
      end else begin
        cnt_q    <= cnt_q + DEB_W'(1);
      end
    end
  end

  logic       press_d;
  logic [1:0] press_idx_d;
  logic       press_q;
  logic [1:0] press_idx_q;

  always_comb begin
    press_d     = |fall_w;
    press_idx_d = 2'd0;
    if (fall_w[0])      press_idx_d = 2'd0;
    else if (fall_w[1]) press_idx_d = 2'd1;
    else if (fall_w[2]) press_idx_d = 2'd2;
    else if (fall_w[3]) press_idx_d = 2'd3;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      press_q     <= 1'b0;
      press_idx_q <= 2'd0;
    end else begin
      press_q     <= press_d;
      press_idx_q <= press_idx_d;
    end
  end

  // Free-running base counter, independent of key activity.
  logic [PER_W-1:0] base_cnt_q;
  logic             tick_w;

  assign tick_w = (base_cnt_q == PER_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      base_cnt_q <= '0;
    end else if (tick_w) begin
      base_cnt_q <= '0;
    end else begin
      base_cnt_q <= base_cnt_q + PER_W'(1);
    end
  end

  logic [1:0]        state_q, state_d;
  logic [2:0]        pattern_q, pattern_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [3:0]        sel_key_q;
  logic [2:0]        press_pat_w;
  logic              same_w;
  logic [2:0]        next_pat_w;

  assign press_pat_w = {1'b0, press_idx_q};
  assign same_w      = (pattern_q == press_pat_w);
  assign next_pat_w  = (pattern_q == 3'd3) ? 3'd0 : pattern_q + 3'd1;

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    step_d    = step_q;
    case (state_q)
      S_IDLE: begin
        if (press_q) begin
          pattern_d = press_pat_w;
          step_d    = '0;
          state_d   = auto_en_i ? S_AUTO : S_MANUAL;
        end else if (auto_en_i) begin
          pattern_d = 3'd0;
          step_d    = '0;
          state_d   = S_AUTO;
        end
      end
      S_MANUAL: begin
        if (press_q && same_w) begin
          pattern_d = PAT_DARK;
          step_d    = '0;
          state_d   = S_IDLE;
        end else if (press_q) begin
          pattern_d = press_pat_w;
          step_d    = '0;
          state_d   = auto_en_i ? S_AUTO : S_MANUAL;
        end else if (auto_en_i) begin
          step_d    = '0;
          state_d   = S_AUTO;
        end
      end
      S_AUTO: begin
        if (!auto_en_i) begin
          // Leaving auto-play: a coincident press behaves as a manual press.
          state_d = S_MANUAL;
          step_d  = '0;
          if (press_q && same_w) begin
            pattern_d = PAT_DARK;
            state_d   = S_IDLE;
          end else if (press_q) begin
            pattern_d = press_pat_w;
          end
        end else if (press_q) begin
          pattern_d = press_pat_w;
          step_d    = '0;
        end else if (tick_w) begin
          if (step_q == STEP_LAST) begin
            step_d    = '0;
            pattern_d = next_pat_w;
          end else begin
            step_d    = step_q + STEP_W'(1);
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        pattern_d = PAT_DARK;
        step_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pattern_q <= PAT_DARK;
      step_q    <= '0;
      sel_key_q <= 4'b1111;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      step_q    <= step_d;
      sel_key_q <= f_sel(pattern_d);
    end
  end

  assign sel_key_o = sel_key_q;
  assign pattern_o = pattern_q;
  assign press_o   = press_q;
  assign tick_o    = tick_w;

endmodule
`default_nettype wire

// File: tb/tb_led_mode_sched.sv
`default_nettype none
// ============================================================================
// tb_led_mode_sched : directed plus randomized bench with a behavioural model.
// Revision          : 1.0  initial release
// ============================================================================
module tb_led_mode_sched;

  localparam int DEB   = 4;
  localparam int PER   = 5;
  localparam int STEPS = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_i;
  logic       auto_en_i;
  logic [3:0] sel_key_o;
  logic [2:0] pattern_o;
  logic       press_o;
  logic       tick_o;

  int errors = 0;
  int checks = 0;
  int n_press = 0;

  always #5 clk = ~clk;

  led_mode_sched #(
    .DEB_MAX   (DEB),
    .PERIOD_MAX(PER),
    .AUTO_STEPS(STEPS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_i    (key_i),
    .auto_en_i(auto_en_i),
    .sel_key_o(sel_key_o),
    .pattern_o(pattern_o),
    .press_o  (press_o),
    .tick_o   (tick_o)
  );

  // Reference model: key delay line, sliding debounce window over synced
  // samples, cycle count since reset for the tick, and a mode/pattern record.
  logic [3:0] m_meta, m_sync, m_stable;
  logic [3:0] m_synq[$];
  logic       m_press;
  int         m_pidx;
  int         m_pat;
  bit         m_auto;
  int         m_step;
  int         m_cyc;

  always @(posedge clk) begin : model
    logic [3:0] nst;
    logic [3:0] falls;
    bit         all_diff;
    bit         tick_now;
    if (rst) begin
      m_meta = 4'hF; m_sync = 4'hF; m_stable = 4'hF;
      m_synq.delete();
      m_press = 1'b0; m_pidx = 0;
      m_pat = 4; m_auto = 0; m_step = 0; m_cyc = 0;
    end else begin
      tick_now = ((m_cyc % PER) == PER - 1);
      if (m_auto && !auto_en_i) m_auto = 0;
      if (m_pat == 4 && !m_press && auto_en_i) begin
        m_pat = 0; m_auto = 1; m_step = 0;
      end else if (m_press) begin
        if (!m_auto && m_pat == m_pidx) begin
          m_pat = 4;
        end else begin
          m_pat = m_pidx; m_step = 0;
          if (auto_en_i) m_auto = 1;
        end
      end else if (m_pat != 4 && !m_auto && auto_en_i) begin
        m_auto = 1; m_step = 0;
      end else if (m_auto && tick_now) begin
        m_step++;
        if (m_step == STEPS) begin
          m_step = 0;
          m_pat = (m_pat + 1) % 4;
        end
      end

      m_synq.push_back(m_sync);
      if (m_synq.size() > DEB) void'(m_synq.pop_front());
      nst = m_stable;
      falls = 4'b0;
      for (int k = 0; k < 4; k++) begin
        if (m_synq.size() == DEB) begin
          all_diff = 1;
          for (int j = 0; j < m_synq.size(); j++)
            if (m_synq[j][k] == m_stable[k]) all_diff = 0;
          if (all_diff) begin
            nst[k] = m_sync[k];
            if (!m_sync[k]) falls[k] = 1'b1;
          end
        end
      end
      m_press = |falls;
      m_pidx = 0;
      for (int k = 3; k >= 0; k--) if (falls[k]) m_pidx = k;
      m_stable = nst;
      m_sync = m_meta;
      m_meta = key_i;
      m_cyc++;
    end
  end

  function automatic logic [3:0] exp_sel(input int p);
    logic [3:0] one;
    if (p > 3) return 4'b1111;
    one = 4'b0001 << p;
    return ~one;
  endfunction

  task automatic check_outputs();
    checks++;
    assert (press_o === m_press) else begin
      errors++; $error("FAIL press: got %b expected %b at t=%0t", press_o, m_press, $time);
    end
    checks++;
    assert (pattern_o === 3'(m_pat)) else begin
      errors++; $error("FAIL pattern: got %0d expected %0d at t=%0t", pattern_o, m_pat, $time);
    end
    checks++;
    assert (sel_key_o === exp_sel(m_pat)) else begin
      errors++; $error("FAIL sel_key: got %b expected %b at t=%0t", sel_key_o, exp_sel(m_pat), $time);
    end
    checks++;
    assert (tick_o === (!rst && (m_cyc % PER) == PER - 1)) else begin
      errors++; $error("FAIL tick: got %b at cyc %0d t=%0t", tick_o, m_cyc, $time);
    end
    if (press_o === 1'b1) n_press++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    assert (got == exp) else begin
      errors++; $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin : stim
    int base;
    int nchg;
    int last;
    int vals[5];
    int at[5];
    int waited;
    rst = 1'b1; key_i = 4'hF; auto_en_i = 1'b0;
    repeat (3) cyc();
    check_val("reset_sel", int'(sel_key_o), 15);
    check_val("reset_pattern", int'(pattern_o), 4);
    check_val("reset_press", int'(press_o), 0);
    check_val("reset_tick", int'(tick_o), 0);
    rst = 1'b0;

    // 1: single held press
    base = n_press;
    key_i = 4'b1110;
    repeat (10) cyc();
    check_val("t1_press_count", n_press - base, 1);
    check_val("t1_pattern", int'(pattern_o), 0);
    check_val("t1_sel", int'(sel_key_o), 4'b1110);
    key_i = 4'hF;
    repeat (10) cyc();

    // 2: bouncing key never settles
    base = n_press;
    for (int i = 0; i < 5; i++) begin
      key_i = 4'b1101; repeat (2) cyc();
      key_i = 4'b1111; repeat (2) cyc();
    end
    check_val("t2_press_count", n_press - base, 0);
    check_val("t2_sel", int'(sel_key_o), 4'b1110);

    // 3: re-press toggles off
    key_i = 4'b1110;
    repeat (10) cyc();
    key_i = 4'hF;
    repeat (10) cyc();
    check_val("t3_pattern", int'(pattern_o), 4);
    check_val("t3_sel", int'(sel_key_o), 4'b1111);

    // 4: auto-play from IDLE
    auto_en_i = 1'b1;
    nchg = 0;
    last = int'(pattern_o);
    for (int c = 0; c < 80 && nchg < 5; c++) begin
      cyc();
      if (int'(pattern_o) != last) begin
        vals[nchg] = int'(pattern_o);
        at[nchg] = c;
        nchg++;
        last = int'(pattern_o);
      end
    end
    check_val("t4_changes", nchg, 5);
    if (nchg == 5) begin
      for (int i = 0; i < 5; i++) check_val("t4_seq", vals[i], i % 4);
      for (int i = 2; i < 5; i++) check_val("t4_interval", at[i] - at[i-1], PER * STEPS);
    end

    rst = 1'b1; auto_en_i = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;

    // 5: simultaneous presses, lowest index wins
    base = n_press;
    key_i = 4'b1010;
    repeat (10) cyc();
    check_val("t5_press_count", n_press - base, 1);
    check_val("t5_pattern", int'(pattern_o), 0);
    key_i = 4'hF;
    repeat (10) cyc();

    // 6: reset during auto at S3 with a press mid-debounce
    auto_en_i = 1'b1;
    waited = 0;
    while (m_pat != 2 && waited < 60) begin
      cyc();
      waited++;
    end
    check_val("t6_reach_s3", m_pat, 2);
    key_i = 4'b0111;
    repeat (2) cyc();
    rst = 1'b1; key_i = 4'hF; auto_en_i = 1'b0;
    cyc();
    check_val("t6_sel_after_rst", int'(sel_key_o), 4'b1111);
    check_val("t6_pattern_after_rst", int'(pattern_o), 4);
    rst = 1'b0;
    base = n_press;
    repeat (20) cyc();
    check_val("t6_no_pending_press", n_press - base, 0);

    // Randomized keys and auto_en against the model
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 0) key_i = 4'hF;
      else key_i = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) auto_en_i = ~auto_en_i;
      repeat ($urandom_range(1, 10)) cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
